// File: rtl/inst_decode_stage.sv
// ---------------------------------------------------------------------------
// inst_decode_stage
//   Registered, buffered instruction-decode stage for the 31-instruction MIPS
//   core. Fetched instructions arrive over a valid/ready handshake, are decoded
//   combinationally into a one-hot class vector plus register/immediate fields,
//   and are queued in a DEPTH-entry FIFO toward the execute stage. The stage
//   also flags illegal encodings and keeps saturating perf counters.
//
// Parameters
//   DEPTH    output FIFO entries (power of 2, >= 2)
//   CNT_W    width of the saturating dec_cnt / ill_cnt counters
//   ILL_BIT  1: illegal instruction sets i_out[31]; 0: i_out = 0 on illegal
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   flush             synchronous FIFO flush (branch/jump redirect)
//   cnt_clr           synchronous clear of both perf counters
//   in_valid/in_ready fetch-side handshake; in_inst / in_pc are the payload
//   out_valid/out_ready execute-side handshake for the FIFO head entry
//   i_out             one-hot instruction class of the head entry
//   ill               head entry is an illegal instruction
//   rs, rt, rd, shamt register / shift fields of the head entry
//   imm_ext           extended immediate of the head entry
//   target            jump target field inst[25:0] of the head entry
//   dst, reg_wr       destination register and its write enable
//   out_pc            pc of the head entry
//   dec_cnt, ill_cnt  legal / illegal instructions accepted (saturating)
// ---------------------------------------------------------------------------
module inst_decode_stage #(
  parameter int DEPTH   = 2,
  parameter int CNT_W   = 16,
  parameter bit ILL_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             cnt_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      i_out,
  output logic             ill,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [31:0]      imm_ext,
  output logic [25:0]      target,
  output logic [4:0]       dst,
  output logic             reg_wr,
  output logic [31:0]      out_pc,
  output logic [CNT_W-1:0] dec_cnt,
  output logic [CNT_W-1:0] ill_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Class index doubles as the bit position in the one-hot vector.
  typedef enum logic [4:0] {
    C_ADD,  C_ADDU, C_SUBU,  C_SUB,  C_AND,   C_OR,    C_XOR,  C_NOR,
    C_SLT,  C_SLTU, C_SLL,   C_SRL,  C_SRA,   C_SLLV,  C_SRLV, C_SRAV,
    C_JR,   C_ADDI, C_ADDIU, C_ANDI, C_ORI,   C_XORI,  C_LW,   C_SW,
    C_BEQ,  C_BNE,  C_SLTI,  C_SLTIU, C_LUI,  C_J,     C_JAL,  C_ILL
  } cls_e;

  typedef struct packed {
    logic [31:0] i_out;
    logic        ill;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [31:0] imm_ext;
    logic [25:0] target;
    logic [4:0]  dst;
    logic        reg_wr;
    logic [31:0] pc;
  } entry_t;

  logic [5:0] op;
  logic [5:0] funct;
  cls_e       cls;
  entry_t     dec;
  entry_t     head;
  entry_t     mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  assign op    = in_inst[31:26];
  assign funct = in_inst[5:0];

  // -------------------------------------------------------------------------
  // Class decode: funct only matters for op = 0 (R-type).
  // -------------------------------------------------------------------------
  always_comb begin
    cls = C_ILL;
    if (op == 6'h00) begin
      case (funct)
        6'h20:   cls = C_ADD;
        6'h21:   cls = C_ADDU;
        6'h23:   cls = C_SUBU;
        6'h22:   cls = C_SUB;
        6'h24:   cls = C_AND;
        6'h25:   cls = C_OR;
        6'h26:   cls = C_XOR;
        6'h27:   cls = C_NOR;
        6'h2a:   cls = C_SLT;
        6'h2b:   cls = C_SLTU;
        6'h00:   cls = C_SLL;
        6'h02:   cls = C_SRL;
        6'h03:   cls = C_SRA;
        6'h04:   cls = C_SLLV;
        6'h06:   cls = C_SRLV;
        6'h07:   cls = C_SRAV;
        6'h08:   cls = C_JR;
        default: cls = C_ILL;
      endcase
    end else begin
      case (op)
        6'h08:   cls = C_ADDI;
        6'h09:   cls = C_ADDIU;
        6'h0c:   cls = C_ANDI;
        6'h0d:   cls = C_ORI;
        6'h0e:   cls = C_XORI;
        6'h23:   cls = C_LW;
        6'h2b:   cls = C_SW;
        6'h04:   cls = C_BEQ;
        6'h05:   cls = C_BNE;
        6'h0a:   cls = C_SLTI;
        6'h0b:   cls = C_SLTIU;
        6'h0f:   cls = C_LUI;
        6'h02:   cls = C_J;
        6'h03:   cls = C_JAL;
        default: cls = C_ILL;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Field extraction, immediate extension and destination selection.
  // -------------------------------------------------------------------------
  always_comb begin
    dec        = '0;
    dec.ill    = (cls == C_ILL);
    dec.rs     = in_inst[25:21];
    dec.rt     = in_inst[20:16];
    dec.rd     = in_inst[15:11];
    dec.shamt  = in_inst[10:6];
    dec.target = in_inst[25:0];
    dec.pc     = in_pc;

    if (cls != C_ILL)
      dec.i_out = 32'd1 << cls;
    else
      dec.i_out = ILL_BIT ? 32'h8000_0000 : '0;

    case (cls)
      C_ADDI, C_ADDIU, C_LW, C_SW, C_BEQ, C_BNE, C_SLTI, C_SLTIU:
        dec.imm_ext = {{16{in_inst[15]}}, in_inst[15:0]};
      C_ANDI, C_ORI, C_XORI:
        dec.imm_ext = {16'h0000, in_inst[15:0]};
      C_LUI:
        dec.imm_ext = {in_inst[15:0], 16'h0000};
      default:
        dec.imm_ext = '0;
    endcase

    case (cls)
      C_ADD, C_ADDU, C_SUBU, C_SUB, C_AND, C_OR, C_XOR, C_NOR,
      C_SLT, C_SLTU, C_SLL, C_SRL, C_SRA, C_SLLV, C_SRLV, C_SRAV: begin
        dec.dst    = in_inst[15:11];
        dec.reg_wr = 1'b1;
      end
      C_ADDI, C_ADDIU, C_ANDI, C_ORI, C_XORI, C_LW, C_SLTI, C_SLTIU, C_LUI: begin
        dec.dst    = in_inst[20:16];
        dec.reg_wr = 1'b1;
      end
      C_JAL: begin
        dec.dst    = 5'd31;
        dec.reg_wr = 1'b1;
      end
      default: begin
        dec.dst    = '0;
        dec.reg_wr = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Handshakes. in_ready already excludes flush and reset, so push never
  // coincides with either.
  // -------------------------------------------------------------------------
  assign in_ready  = (count < CW'(DEPTH)) & ~flush & ~rst;
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Storage is written per entry so every slot can be cleared at reset with
  // constant indices, keeping the payload outputs at zero out of reset.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    always_ff @(posedge clk) begin
      if (rst)
        mem[g] <= '0;
      else if (push && (wr_ptr == PW'(g)))
        mem[g] <= dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // Emptying by aligning the read pointer; stale payload stays visible
      // but out_valid is low.
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Saturating perf counters; clear wins over a same-cycle increment.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      dec_cnt <= '0;
      ill_cnt <= '0;
    end else if (push) begin
      if (dec.ill) begin
        if (ill_cnt != '1)
          ill_cnt <= ill_cnt + 1'b1;
      end else begin
        if (dec_cnt != '1)
          dec_cnt <= dec_cnt + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Head-of-FIFO outputs.
  // -------------------------------------------------------------------------
  assign head    = mem[rd_ptr];
  assign i_out   = head.i_out;
  assign ill     = head.ill;
  assign rs      = head.rs;
  assign rt      = head.rt;
  assign rd      = head.rd;
  assign shamt   = head.shamt;
  assign imm_ext = head.imm_ext;
  assign target  = head.target;
  assign dst     = head.dst;
  assign reg_wr  = head.reg_wr;
  assign out_pc  = head.pc;

endmodule

// File: tb/tb_inst_decode_stage.sv
module tb_inst_decode_stage;

  localparam int DEPTH = 2;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             cnt_clr;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [31:0]      in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      i_out;
  logic             ill;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [4:0]       shamt;
  logic [31:0]      imm_ext;
  logic [25:0]      target;
  logic [4:0]       dst;
  logic             reg_wr;
  logic [31:0]      out_pc;
  logic [CNT_W-1:0] dec_cnt;
  logic [CNT_W-1:0] ill_cnt;

  always #5 clk = ~clk;

  inst_decode_stage #(
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W),
    .ILL_BIT(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .cnt_clr  (cnt_clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_inst  (in_inst),
    .in_pc    (in_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .i_out    (i_out),
    .ill      (ill),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .shamt    (shamt),
    .imm_ext  (imm_ext),
    .target   (target),
    .dst      (dst),
    .reg_wr   (reg_wr),
    .out_pc   (out_pc),
    .dec_cnt  (dec_cnt),
    .ill_cnt  (ill_cnt)
  );

  typedef struct {
    logic [31:0] iout;
    logic        ill;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic [25:0] target;
    logic [4:0]  dst;
    logic        wr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t trk_e;
  bit   acc;
  int   n_cmp = 0;
  int   n_err = 0;
  int   dec_m = 0;
  int   ill_m = 0;

  // Instruction table: class k<17 is R-type with funct r_fn[k];
  // class 17+k is the opcode i_op[k].
  int unsigned r_fn[17] = '{32'h20, 32'h21, 32'h23, 32'h22, 32'h24, 32'h25, 32'h26, 32'h27,
                            32'h2a, 32'h2b, 32'h00, 32'h02, 32'h03, 32'h04, 32'h06, 32'h07,
                            32'h08};
  int unsigned i_op[14] = '{32'h08, 32'h09, 32'h0c, 32'h0d, 32'h0e, 32'h23, 32'h2b,
                            32'h04, 32'h05, 32'h0a, 32'h0b, 32'h0f, 32'h02, 32'h03};

  function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
    exp_t        e;
    int          cls = 31;
    int unsigned op  = 32'(inst[31:26]);
    int unsigned fn  = 32'(inst[5:0]);
    if (op == 0) begin
      for (int k = 0; k < 17; k++) if (r_fn[k] == fn) cls = k;
    end else begin
      for (int k = 0; k < 14; k++) if (i_op[k] == op) cls = 17 + k;
    end
    e.ill    = (cls == 31);
    e.iout   = 32'h1 << cls;
    e.rs     = inst[25:21];
    e.rt     = inst[20:16];
    e.rd     = inst[15:11];
    e.shamt  = inst[10:6];
    e.target = inst[25:0];
    e.pc     = pc;
    if (cls inside {17, 18, 22, 23, 24, 25, 26, 27})
      e.imm = 32'(signed'(inst[15:0]));
    else if (cls inside {19, 20, 21})
      e.imm = 32'(inst[15:0]);
    else if (cls == 28)
      e.imm = 32'(inst[15:0]) * 32'd65536;
    else
      e.imm = 32'h0;
    if (cls <= 15) begin
      e.dst = inst[15:11]; e.wr = 1'b1;
    end else if (cls inside {[17:22], 26, 27, 28}) begin
      e.dst = inst[20:16]; e.wr = 1'b1;
    end else if (cls == 30) begin
      e.dst = 5'd31; e.wr = 1'b1;
    end else begin
      e.dst = 5'd0; e.wr = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w   = $urandom;
    logic [31:0] t;
    int          cls = int'($urandom_range(0, 30));
    if ($urandom_range(0, 4) == 0) return w;
    if (cls < 17) begin
      t = r_fn[cls];
      return {6'h00, w[25:6], t[5:0]};
    end
    t = i_op[cls - 17];
    return {t[5:0], w[25:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares handshake state every cycle and pops the head on a pop.
  always @(negedge clk) begin
    #3;
    check("in_ready", 64'(in_ready), 64'(!rst && !flush && (sb.size() < DEPTH)));
    check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    check("dec_cnt", 64'(dec_cnt), 64'(dec_m));
    check("ill_cnt", 64'(ill_cnt), 64'(ill_m));
    if (out_valid && out_ready && sb.size() != 0) begin
      mon_e = sb.pop_front();
      check("i_out",   64'(i_out),   64'(mon_e.iout));
      check("ill",     64'(ill),     64'(mon_e.ill));
      check("rs",      64'(rs),      64'(mon_e.rs));
      check("rt",      64'(rt),      64'(mon_e.rt));
      check("rd",      64'(rd),      64'(mon_e.rd));
      check("shamt",   64'(shamt),   64'(mon_e.shamt));
      check("imm_ext", 64'(imm_ext), 64'(mon_e.imm));
      check("target",  64'(target),  64'(mon_e.target));
      check("dst",     64'(dst),     64'(mon_e.dst));
      check("reg_wr",  64'(reg_wr),  64'(mon_e.wr));
      check("out_pc",  64'(out_pc),  64'(mon_e.pc));
    end
  end

  // Tracker: records each accepted instruction's expected decode and the
  // counter model, just before the active edge.
  always @(negedge clk) begin
    #4;
    acc = in_valid && in_ready && !rst && !flush;
    if (acc) trk_e = model(in_inst, in_pc);
    if (rst || flush) sb.delete();
    else if (acc) sb.push_back(trk_e);
    if (rst || cnt_clr) begin
      dec_m = 0;
      ill_m = 0;
    end else if (acc) begin
      if (trk_e.ill) ill_m = (ill_m < CMAX) ? ill_m + 1 : ill_m;
      else           dec_m = (dec_m < CMAX) ? dec_m + 1 : dec_m;
    end
  end

  // Called at a negedge; returns at a negedge with in_valid dropped.
  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    int unsigned n    = 0;
    bit          done = 1'b0;
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    while (!done) begin
      #4;
      if (in_ready) begin
        done = 1'b1;
      end else if (n >= 100) begin
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: got no in_ready expected accept for inst 0x%08h", inst);
        done = 1'b1;
      end
      n++;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0;
    in_inst = '0; in_pc = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_i_out",   64'(i_out),   64'h0);
    check("rst_imm_ext", 64'(imm_ext), 64'h0);
    check("rst_out_pc",  64'(out_pc),  64'h0);
    check("rst_target",  64'(target),  64'h0);
    check("rst_dst",     64'(dst),     64'h0);
    check("rst_reg_wr",  64'(reg_wr),  64'h0);
    rst = 1'b0;

    // Directed vectors.
    send(32'h0022_1820, 32'h0000_0100);
    repeat (2) @(negedge clk);
    send(32'h2022_FFFF, 32'h0000_0104);
    send(32'h3422_8000, 32'h0000_0108);
    send(32'h3C01_1234, 32'h0000_010C);
    send(32'h0C00_0010, 32'h0000_0110);
    send(32'hAC22_0004, 32'h0000_0114);
    send(32'hFC00_0000, 32'h0000_0118);
    send(32'h0000_003F, 32'h0000_011C);
    repeat (2) @(negedge clk);

    // Backpressure: third instruction stalls until the head drains.
    out_ready = 1'b0;
    send(32'h0022_1820, 32'h0000_0000);
    send(32'h2022_FFFF, 32'h0000_0004);
    in_valid = 1'b1; in_inst = 32'h3C01_1234; in_pc = 32'h0000_0008;
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    send(32'h3C01_1234, 32'h0000_0008);
    repeat (3) @(negedge clk);

    // Flush with two queued and an instruction offered in the flush cycle.
    out_ready = 1'b0;
    send(32'h0022_1820, 32'h0000_0200);
    send(32'h0000_003F, 32'h0000_0204);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h0022_1820; in_pc = 32'h0000_0208;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    out_ready = 1'b1;

    // Clear has priority over a same-cycle increment.
    cnt_clr = 1'b1;
    send(32'h0022_1820, 32'h0000_0300);
    cnt_clr = 1'b0;
    repeat (2) @(negedge clk);

    // Reset with entries queued.
    out_ready = 1'b0;
    send(32'h2022_FFFF, 32'h0000_0400);
    send(32'hFC00_0000, 32'h0000_0404);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Saturation of both counters.
    for (int i = 0; i < CMAX + 3; i++) send(32'h0022_1820 ^ (32'(i) << 21), 32'(i) * 4);
    for (int i = 0; i < CMAX + 3; i++) send({6'h3F, 26'(i)}, 32'(i) * 4);
    repeat (2) @(negedge clk);

    // Randomised traffic with stalls, flushes, clears and rare resets.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      cnt_clr   = ($urandom_range(0, 99) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_inst   = rand_inst();
      in_pc     = $urandom;
      @(negedge clk);
    end
    rst = 1'b0; flush = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("drain_empty", 64'(sb.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
